bcd_join: RTL and testbench
===========================

BCD_JOIN -- requirements
Module: bcd_join

Interface
REQ-001 The block SHALL have parameter NDIG, default 4: number of BCD digits per word.
REQ-002 The block SHALL have parameter OUT_W, default 16: binary result width; OUT_W >= ceil(log2(10^NDIG)) is required.
REQ-003 The block SHALL have port clk  input  1  system clock; the block uses one clock, all logic on the rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 The block SHALL have port in  input  4*NDIG  BCD digits; in[3:0] is ones, the most significant nibble is the top digit.
REQ-006 The block SHALL have port in_valid  input  1  the in word is offered.
REQ-007 The block SHALL have port in_ready  output  1  the block can accept a word.
REQ-008 The block SHALL have port out  output  OUT_W  binary value of the accepted digits.
REQ-009 The block SHALL have port out_valid  output  1  out (and err) is valid.
REQ-010 The block SHALL have port out_ready  input  1  the consumer takes out.
REQ-011 The block SHALL have port err  output  1  at least one accepted digit was >9; qualified by out_valid.

Function
REQ-012 The FSM SHALL have states IDLE, CONV and DONE.
REQ-013 IDLE SHALL drive in_ready=1; in CONV and DONE, in_ready SHALL be 0.
REQ-014 On an input handshake (in_valid & in_ready at an edge), the block SHALL capture in into a shift register, clear the accumulator and the digit counter, and go to CONV.
REQ-015 In CONV, each cycle SHALL do acc <= acc*10 + top nibble (*10 as (acc<<3)+(acc<<1)), shift the digit register left 4, and increment the counter.
REQ-016 After NDIG CONV cycles the FSM SHALL go to DONE; out_valid SHALL rise exactly NDIG edges after the input-handshake edge.
REQ-017 In DONE, out_valid=1, and out and err SHALL stay stable until out_ready=1 at an edge, then the FSM returns to IDLE.
REQ-018 The block SHALL NOT accept a new input on the same edge as the output handshake; in_ready rises the following cycle, so the minimum accept-to-accept interval is NDIG+2 cycles.
REQ-019 out_ready asserted while out_valid=0 SHALL have no effect; in_valid while in_ready=0 SHALL be ignored and the offered word is not captured.
REQ-020 The accumulator SHALL be OUT_W wide; intermediate products SHALL be computed in OUT_W+4 bits and truncated to OUT_W.
REQ-021 All-zero digits SHALL yield out=0; all-nines SHALL yield 10^NDIG-1 (9999 at default).

Reset
REQ-022 Asserting rst_n low SHALL immediately force: state=IDLE, in_ready=1, out_valid=0, out=0, err=0, counter=0, accumulator=0.
REQ-023 Reset in CONV or DONE SHALL abort the operation; the partial result SHALL be discarded and never presented.
REQ-024 After rst_n deasserts, the first input handshake SHALL be possible on the first rising edge.

Configuration
REQ-025 The macro BCD_JOIN_RANGE_CHECK_EN SHALL control digit range checking.
REQ-026 With BCD_JOIN_RANGE_CHECK_EN defined, any digit >9 consumed in CONV SHALL set a sticky err flag that is cleared on input handshake; out is still the truncated arithmetic result.
REQ-027 Without BCD_JOIN_RANGE_CHECK_EN, err SHALL be tied to 0 and nibbles SHALL be used as raw 0..15 values.

Verification
REQ-028 The bench SHALL cover: in=16'h1000 (BCD "1000"), handshake at edge k, out_ready=1 -> out_valid at edge k+4, out=16'd1000, err=0.
REQ-029 The bench SHALL cover: in=16'h2500, then 16'h8400, back-to-back -> out=2500 then 8400; second in_ready rises one cycle after the first output handshake.
REQ-030 The bench SHALL cover: in=16'h9999 with out_ready=0 for 10 cycles -> out_valid held, out=9999 stable, in_ready=0 throughout; release -> IDLE next cycle.
REQ-031 The bench SHALL cover: in=16'h12A4 -> with BCD_JOIN_RANGE_CHECK_EN, err=1 and out=1304; without it, err=0 and out=1304.
REQ-032 The bench SHALL cover: rst_n pulsed low two cycles after accepting 16'h0042 -> out_valid never asserts, in_ready=1 during reset; then 16'h0042 -> out=42.
REQ-033 The bench SHALL cover: in_valid=1 with in=16'h0007 while in CONV -> ignored; only the previously accepted word's result appears.

Source files
------------

// File: rtl/bcd_join.sv
// bcd_join: serial BCD-to-binary converter, one digit per cycle, valid/ready on both sides.
// Optional macro BCD_JOIN_RANGE_CHECK_EN enables a sticky err flag for digits above 9.
module bcd_join #(
  parameter int NDIG  = 4,
  parameter int OUT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4*NDIG-1:0]   in,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [OUT_W-1:0]    out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                err
);

  localparam int IW = 4 * NDIG;
  localparam int CW = (NDIG < 2) ? 1 : $clog2(NDIG + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [IW-1:0]     dig;
  logic [OUT_W-1:0]  acc;
  logic [CW-1:0]     cnt;
  logic [3:0]        top;
  logic              accept;
  logic              last;

  // acc*10 + d evaluated 4 bits wider than the accumulator, then truncated
  function automatic logic [OUT_W-1:0] mac10(input logic [OUT_W-1:0] a,
                                             input logic [3:0]       d);
    logic [OUT_W+3:0] w;
    w = {4'b0000, a};
    return OUT_W'((w << 3) + (w << 1) + {{OUT_W{1'b0}}, d});
  endfunction

  assign top    = dig[IW-1 -: 4];
  assign accept = in_valid && (state == IDLE);
  assign last   = (cnt == CW'(NDIG - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = CONV;
      CONV:    if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      acc <= '0;
      cnt <= '0;
    end else if (state == CONV) begin
      acc <= mac10(acc, top);
      cnt <= cnt + 1'b1;
    end
  end

  // Digit shift register carries data only; control decides when it is meaningful
  always_ff @(posedge clk) begin
    if (accept)              dig <= in;
    else if (state == CONV)  dig <= dig << 4;
  end

`ifdef BCD_JOIN_RANGE_CHECK_EN
  logic errf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          errf <= 1'b0;
    else if (accept)                     errf <= 1'b0;
    else if (state == CONV && top > 4'd9) errf <= 1'b1;
  end

  assign err = errf;
`else
  assign err = 1'b0;
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out       = acc;

endmodule

// File: tb/tb_bcd_join.sv
// Directed, table-driven bench for bcd_join at default parameters (NDIG=4, OUT_W=16).
module tb_bcd_join;

  logic        clk;
  logic        rst_n;
  logic [15:0] in;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out;
  logic        out_valid;
  logic        out_ready;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef BCD_JOIN_RANGE_CHECK_EN
  localparam logic ERR_A4 = 1'b1;
`else
  localparam logic ERR_A4 = 1'b0;
`endif

  bcd_join #(.NDIG(4), .OUT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] din;
    int          hold;
    logic [15:0] exp;
    logic        exp_err;
    string       name;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one word, measure latency, check the result over 'hold' stalled cycles, then retire it
  task automatic send(input logic [15:0] d, input int hold, input logic [15:0] exp,
                      input logic exp_err, input string nm);
    int w;
    int lat;
    w = 0;
    while (!in_ready && w < 20) begin
      step();
      w++;
    end
    chk({nm, " in_ready_before"}, 32'(in_ready), 32'd1);
    in       = d;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in       = 16'hFFFF;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!out_valid && lat < 20);
    chk({nm, " latency"}, 32'(lat), 32'd4);
    chk({nm, " out"}, 32'(out), 32'(exp));
    chk({nm, " err"}, 32'(err), 32'(exp_err));
    for (int i = 0; i < hold; i++) begin
      step();
      chk({nm, " hold_valid"}, 32'(out_valid), 32'd1);
      chk({nm, " hold_out"}, 32'(out), 32'(exp));
      chk({nm, " hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({nm, " in_ready_after"}, 32'(in_ready), 32'd1);
    chk({nm, " out_valid_after"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int lat;

    tbl[0] = '{16'h1000, 0, 16'd1000, 1'b0, "w1000"};
    tbl[1] = '{16'h2500, 0, 16'd2500, 1'b0, "w2500"};
    tbl[2] = '{16'h8400, 0, 16'd8400, 1'b0, "w8400"};
    tbl[3] = '{16'h9999, 10, 16'd9999, 1'b0, "w9999_stall"};
    tbl[4] = '{16'h12A4, 0, 16'd1304, ERR_A4, "w12A4"};
    tbl[5] = '{16'h0000, 0, 16'd0, 1'b0, "w0000"};
    tbl[6] = '{16'h0305, 0, 16'd305, 1'b0, "w0305"};
    tbl[7] = '{16'h0001, 0, 16'd1, 1'b0, "w0001"};

    rst_n     = 1'b0;
    in        = 16'h0000;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out", 32'(out), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    step();
    step();
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      send(tbl[i].din, tbl[i].hold, tbl[i].exp, tbl[i].exp_err, tbl[i].name);

    // out_ready while nothing is pending must not disturb the idle block
    out_ready = 1'b1;
    step();
    step();
    out_ready = 1'b0;
    chk("stray out_ready out_valid", 32'(out_valid), 32'd0);
    chk("stray out_ready in_ready", 32'(in_ready), 32'd1);

    // A word offered during CONV is ignored
    in       = 16'h0305;
    in_valid = 1'b1;
    step();
    in       = 16'h0007;
    step();
    step();
    chk("ignore in_ready_conv", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    lat = 2;
    do begin
      step();
      lat++;
    end while (!out_valid && lat < 20);
    chk("ignore latency", 32'(lat), 32'd4);
    chk("ignore out", 32'(out), 32'd305);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    step();
    chk("ignore idle in_ready", 32'(in_ready), 32'd1);
    chk("ignore idle out_valid", 32'(out_valid), 32'd0);

    // Reset mid-conversion discards the partial result
    in       = 16'h0042;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("abort in_ready", 32'(in_ready), 32'd1);
    chk("abort out_valid", 32'(out_valid), 32'd0);
    chk("abort out", 32'(out), 32'd0);
    chk("abort err", 32'(err), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort hold out_valid", 32'(out_valid), 32'd0);
      chk("abort hold in_ready", 32'(in_ready), 32'd1);
    end
    rst_n = 1'b1;
    send(16'h0042, 0, 16'd42, 1'b0, "after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
